// File: rtl/i2c_reg_seq_if.sv
// Request/response and i2c_master command bundle for the register sequencer.
// slave = sequencer side, master = requester plus i2c_master side.
interface i2c_reg_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rnw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_timeout;
  logic       busy;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr_i2c;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;

  modport slave (
    input  req_valid, req_rnw, req_dev_addr,
    input  req_reg_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_nack, rsp_timeout, busy,
    output m_cmd, m_din, m_wr_i2c,
    input  m_ready, m_done_tick, m_ack, m_dout
  );

  modport master (
    output req_valid, req_rnw, req_dev_addr,
    output req_reg_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_nack, rsp_timeout, busy,
    input  m_cmd, m_din, m_wr_i2c,
    output m_ready, m_done_tick, m_ack, m_dout
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// Register read/write sequencer driving i2c_master from START to STOP.
// One request in flight; result returned as a one-cycle response pulse.
module i2c_reg_seq #(
  parameter bit ABORT_ON_NACK = 1'b1,
  parameter int WAIT_TIMEOUT  = 65535
) (
  input logic          clk,
  input logic          reset,
  i2c_reg_seq_if.slave bus
);
  localparam logic [2:0] C_START   = 3'd0;
  localparam logic [2:0] C_WR      = 3'd1;
  localparam logic [2:0] C_RD      = 3'd2;
  localparam logic [2:0] C_STOP    = 3'd3;
  localparam logic [2:0] C_RESTART = 3'd4;
  localparam logic [15:0] TO_LAST  = 16'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rnw;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg;
  logic [7:0]  r_wdata;
  logic [2:0]  r_step, w_step_nxt;
  logic [2:0]  r_cmd;
  logic [7:0]  r_din;
  logic [15:0] r_cnt;
  logic [7:0]  r_rdata;
  logic        r_nack;
  logic        r_timeout;

  logic        w_accept, w_done, w_last;
  logic        w_nack, w_abort, w_timeout;
  logic [2:0]  w_stop_step;
  logic [10:0] w_dec;

  function automatic logic [10:0] f_decode(
    input logic       rnw,
    input logic [2:0] step,
    input logic [6:0] dev,
    input logic [7:0] rg,
    input logic [7:0] wd
  );
    logic [2:0] c;
    logic [7:0] d;
    c = C_STOP;
    d = 8'h00;
    unique case (1'b1)
      step == 3'd0: c = C_START;
      step == 3'd1: begin c = C_WR; d = {dev, 1'b0}; end
      step == 3'd2: begin c = C_WR; d = rg; end
      step == 3'd3 && !rnw: begin c = C_WR; d = wd; end
      step == 3'd3 && rnw: c = C_RESTART;
      step == 3'd4 && rnw: begin c = C_WR; d = {dev, 1'b1}; end
      step == 3'd5 && rnw: begin c = C_RD; d = 8'h01; end
      default: ;
    endcase
    return {c, d};
  endfunction

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_done      = (r_state == S_WAIT) && bus.m_done_tick;
  assign w_stop_step = r_rnw ? 3'd6 : 3'd4;
  assign w_last      = (r_step == w_stop_step);
  // A NACK reported this very cycle must already steer the next step
  assign w_nack      = r_nack | (w_done & (r_cmd == C_WR) & bus.m_ack);
  assign w_abort     = w_nack && ABORT_ON_NACK &&
                       ((r_step + 3'd1) != w_stop_step);
  assign w_timeout   = (r_state == S_WAIT) && !bus.m_ready &&
                       (r_cnt == TO_LAST);
  assign w_dec       = f_decode(r_rnw, w_step_nxt, r_dev, r_reg, r_wdata);

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    unique case (r_state)
      S_IDLE:
        if (bus.req_valid) begin
          w_state_nxt = S_ISSUE;
          w_step_nxt  = 3'd0;
        end
      S_ISSUE:
        if (bus.m_ready) w_state_nxt = S_WAIT;
      S_WAIT:
        if (bus.m_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
            w_step_nxt  = w_abort ? w_stop_step : r_step + 3'd1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
        end
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_step    <= 3'd0;
      r_rnw     <= 1'b0;
      r_dev     <= 7'd0;
      r_reg     <= 8'd0;
      r_wdata   <= 8'd0;
      r_cmd     <= C_START;
      r_din     <= 8'd0;
      r_cnt     <= 16'd0;
      r_rdata   <= 8'd0;
      r_nack    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_step         <= w_step_nxt;
      {r_cmd, r_din} <= w_dec;
      if (w_accept) begin
        r_rnw     <= bus.req_rnw;
        r_dev     <= bus.req_dev_addr;
        r_reg     <= bus.req_reg_addr;
        r_wdata   <= bus.req_wdata;
        r_rdata   <= 8'd0;
        r_nack    <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (r_state == S_ISSUE) r_cnt <= 16'd0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
      if (w_done && r_cmd == C_WR && bus.m_ack) r_nack <= 1'b1;
      if (w_done && r_cmd == C_RD) r_rdata <= bus.m_dout;
      if (w_timeout) r_timeout <= 1'b1;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.rsp_valid   = (r_state == S_DONE);
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_nack    = r_nack;
  assign bus.rsp_timeout = r_timeout;
  assign bus.m_cmd       = r_cmd;
  assign bus.m_din       = r_din;
  assign bus.m_wr_i2c    = (r_state == S_ISSUE) && bus.m_ready;
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: emulated i2c_master/slave plus a
// transaction-level reference of the expected command list.
module tb_i2c_reg_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  i2c_reg_seq_if bus();

  i2c_reg_seq #(
    .ABORT_ON_NACK(1'b1),
    .WAIT_TIMEOUT (100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];
  bit          nk_q[$];
  bit          ack_q[$];
  logic [7:0]  slave_rd = 8'h00;
  bit          stall = 1'b0;
  int          viol = 0;
  int          issue_cyc = 0;
  int          min_dur = 1;
  int          max_dur = 4;

  bit          exp_nack;
  logic [7:0]  exp_rdata;
  int          g_idx;
  logic [10:0] g_got, g_exp;

  logic [7:0]  o_rdata;
  bit          o_nack, o_to, o_got;
  int          o_len, o_rsp_cyc;

  // Emulated i2c_master: busy for a random time per command, then
  // done_tick for WR/RD with ready returning same or next cycle.
  initial begin : master
    int   ph;
    int   rem;
    bit   rpend;
    logic [2:0] cur;
    ph = 0; rem = 0; rpend = 0; cur = 3'd0;
    bus.m_ready = 1'b1;
    bus.m_done_tick = 1'b0;
    bus.m_ack = 1'b0;
    bus.m_dout = 8'h00;
    forever begin
      @(negedge clk);
      bus.m_done_tick = 1'b0;
      if (reset) begin
        ph = 0; rpend = 0;
        bus.m_ready = 1'b1;
      end else begin
        if (rpend) begin
          bus.m_ready = 1'b1;
          rpend = 0;
        end
        if (ph == 1) begin
          ph = 2;
          bus.m_ready = 1'b0;
          rem = $urandom_range(max_dur, min_dur);
        end else if (ph == 2 && !stall) begin
          rem--;
          if (rem <= 0) begin
            ph = 0;
            if (cur == 3'd1 || cur == 3'd2) begin
              bus.m_done_tick = 1'b1;
              bus.m_ack = 1'b1;
              bus.m_dout = 8'($urandom);
              if (cur == 3'd1) begin
                bus.m_ack = 1'b0;
                if (ack_q.size() > 0) bus.m_ack = ack_q.pop_front();
              end else begin
                bus.m_dout = slave_rd;
              end
              rpend = bit'($urandom_range(1, 0));
              if (!rpend) bus.m_ready = 1'b1;
            end else begin
              bus.m_ready = 1'b1;
            end
          end
        end
      end
      #1;
      if (bus.m_wr_i2c) begin
        if (!bus.m_ready || ph != 0 || rpend) begin
          viol++;
        end else begin
          log_q.push_back({bus.m_cmd, bus.m_din});
          cur = bus.m_cmd;
          issue_cyc = cyc;
          ph = 1;
        end
      end
    end
  end

  // Expected command list from the register-access rules.
  function automatic void model(
    input bit         rnw,
    input logic [6:0] dev,
    input logic [7:0] rg,
    input logic [7:0] wd,
    input logic [7:0] rd
  );
    logic [10:0] prog[$];
    int w;
    prog.push_back({3'd0, 8'h00});
    prog.push_back({3'd1, dev, 1'b0});
    prog.push_back({3'd1, rg});
    if (rnw) begin
      prog.push_back({3'd4, 8'h00});
      prog.push_back({3'd1, dev, 1'b1});
      prog.push_back({3'd2, 8'h01});
    end else begin
      prog.push_back({3'd1, wd});
    end
    prog.push_back({3'd3, 8'h00});
    exp_q.delete();
    exp_nack = 0;
    exp_rdata = 8'h00;
    w = 0;
    for (int i = 0; i < prog.size(); i++) begin
      exp_q.push_back(prog[i]);
      if (prog[i][10:8] == 3'd3) break;
      if (prog[i][10:8] == 3'd1) begin
        if (w < nk_q.size() && nk_q[w]) exp_nack = 1;
        w++;
      end
      if (prog[i][10:8] == 3'd2) exp_rdata = rd;
      if (exp_nack && prog[i+1][10:8] != 3'd3) begin
        exp_q.push_back({3'd3, 8'h00});
        break;
      end
    end
  endfunction

  function automatic bit seq_match();
    int n;
    n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g_idx = i;
      g_got = (i < log_q.size()) ? log_q[i] : 11'h7ff;
      g_exp = (i < exp_q.size()) ? exp_q[i] : 11'h7ff;
      if (g_got !== g_exp) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_req(
    input bit         rnw,
    input logic [6:0] dev,
    input logic [7:0] rg,
    input logic [7:0] wd
  );
    int n;
    log_q.delete();
    ack_q = nk_q;
    o_got = 0; o_len = 0; o_rsp_cyc = 0;
    o_rdata = 8'h00; o_nack = 0; o_to = 0;
    @(negedge clk);
    bus.req_rnw = rnw;
    bus.req_dev_addr = dev;
    bus.req_reg_addr = rg;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.rsp_valid) begin
      o_got = 1;
      o_rsp_cyc = cyc;
      o_rdata = bus.rsp_rdata;
      o_nack = bus.rsp_nack;
      o_to = bus.rsp_timeout;
      while (bus.rsp_valid && o_len < 5) begin
        o_len++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset_ready got=%b%b exp=10", bus.req_ready, bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
    else n_pass++;
    n_chk++;
    if ({bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout} !== 10'd0)
      $display("FAIL reset_rsp got=%h/%b/%b exp=0", bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout);
    else n_pass++;
    n_chk++;
    if ({bus.m_wr_i2c, bus.m_cmd, bus.m_din} !== 12'd0)
      $display("FAIL reset_master got=%b/%0d/%h exp=0", bus.m_wr_i2c, bus.m_cmd, bus.m_din);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_write();
    nk_q.delete();
    slave_rd = 8'h99;
    run_req(1'b0, 7'h50, 8'h10, 8'hA5);
    model(1'b0, 7'h50, 8'h10, 8'hA5, slave_rd);
    n_chk++;
    if (o_got !== 1'b1 || o_len !== 1)
      $display("FAIL write_pulse got=%0b len=%0d exp=1 len=1", o_got, o_len);
    else n_pass++;
    n_chk++;
    if (!seq_match())
      $display("FAIL write_seq idx=%0d got=%h exp=%h", g_idx, g_got, g_exp);
    else n_pass++;
    n_chk++;
    if ({o_rdata, o_nack, o_to} !== 10'd0)
      $display("FAIL write_rsp got=%h/%b/%b exp=00/0/0", o_rdata, o_nack, o_to);
    else n_pass++;
  endtask

  task automatic test_read();
    nk_q.delete();
    slave_rd = 8'h3C;
    run_req(1'b1, 7'h50, 8'h22, 8'h77);
    model(1'b1, 7'h50, 8'h22, 8'h77, slave_rd);
    n_chk++;
    if (o_got !== 1'b1 || o_len !== 1)
      $display("FAIL read_pulse got=%0b len=%0d exp=1 len=1", o_got, o_len);
    else n_pass++;
    n_chk++;
    if (!seq_match())
      $display("FAIL read_seq idx=%0d got=%h exp=%h", g_idx, g_got, g_exp);
    else n_pass++;
    n_chk++;
    if (o_rdata !== 8'h3C || o_nack !== 1'b0 || o_to !== 1'b0)
      $display("FAIL read_rsp got=%h/%b/%b exp=3c/0/0", o_rdata, o_nack, o_to);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.rsp_rdata !== 8'h3C)
      $display("FAIL read_hold got=%h exp=3c", bus.rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_nack_abort();
    nk_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_req(1'b0, 7'h7F, 8'h05, 8'h5A);
    exp_q = '{11'h000, {3'd1, 8'hFE}, {3'd3, 8'h00}};
    n_chk++;
    if (!seq_match())
      $display("FAIL nack_seq idx=%0d got=%h exp=%h", g_idx, g_got, g_exp);
    else n_pass++;
    n_chk++;
    if (o_got !== 1'b1 || o_nack !== 1'b1 || o_to !== 1'b0)
      $display("FAIL nack_rsp got=%b/%b/%b exp=1/1/0", o_got, o_nack, o_to);
    else n_pass++;
  endtask

  task automatic test_random();
    bit         rnw;
    logic [6:0] dev;
    logic [7:0] rg, wd;
    for (int it = 0; it < 30; it++) begin
      rnw = bit'($urandom_range(1, 0));
      dev = 7'($urandom);
      rg = 8'($urandom);
      wd = 8'($urandom);
      slave_rd = 8'($urandom);
      min_dur = 1;
      max_dur = $urandom_range(6, 1);
      nk_q.delete();
      for (int k = 0; k < 4; k++) nk_q.push_back($urandom_range(4, 0) == 0);
      run_req(rnw, dev, rg, wd);
      model(rnw, dev, rg, wd, slave_rd);
      n_chk++;
      if (o_got !== 1'b1 || o_len !== 1)
        $display("FAIL rand%0d_pulse got=%0b len=%0d exp=1 len=1", it, o_got, o_len);
      else n_pass++;
      n_chk++;
      if (!seq_match())
        $display("FAIL rand%0d_seq idx=%0d got=%h exp=%h", it, g_idx, g_got, g_exp);
      else n_pass++;
      n_chk++;
      if (o_nack !== exp_nack || o_to !== 1'b0)
        $display("FAIL rand%0d_nack got=%b/%b exp=%b/0", it, o_nack, o_to, exp_nack);
      else n_pass++;
      n_chk++;
      if (o_rdata !== exp_rdata)
        $display("FAIL rand%0d_rdata got=%h exp=%h", it, o_rdata, exp_rdata);
      else n_pass++;
    end
    min_dur = 1;
    max_dur = 4;
  endtask

  task automatic test_timeout();
    nk_q.delete();
    stall = 1'b1;
    run_req(1'b0, 7'h21, 8'h33, 8'h44);
    n_chk++;
    if (o_got !== 1'b1 || o_to !== 1'b1 || o_nack !== 1'b0)
      $display("FAIL timeout_rsp got=%b/%b/%b exp=1/1/0", o_got, o_to, o_nack);
    else n_pass++;
    n_chk++;
    if (o_rsp_cyc - issue_cyc !== 101)
      $display("FAIL timeout_len got=%0d exp=101", o_rsp_cyc - issue_cyc);
    else n_pass++;
    exp_q = '{11'h000};
    n_chk++;
    if (!seq_match())
      $display("FAIL timeout_seq idx=%0d got=%h exp=%h", g_idx, g_got, g_exp);
    else n_pass++;
    stall = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    nk_q.delete();
    ack_q.delete();
    log_q.delete();
    min_dur = 3;
    max_dur = 3;
    @(negedge clk);
    bus.req_rnw = 1'b0;
    bus.req_dev_addr = 7'h50;
    bus.req_reg_addr = 8'h10;
    bus.req_wdata = 8'hA5;
    bus.req_valid = 1'b1;
    n = 0;
    while (log_q.size() < 3 && n < 300) begin
      @(negedge clk);
      if (!bus.req_ready) bus.req_valid = 1'b0;
      n++;
    end
    bus.req_valid = 1'b0;
    n_chk++;
    if (log_q.size() !== 3)
      $display("FAIL midreset_reach got=%0d exp=3", log_q.size());
    else n_pass++;
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL midreset_ctl got=%b%b%b exp=100", bus.req_ready, bus.busy, bus.rsp_valid);
    else n_pass++;
    n_chk++;
    if ({bus.m_wr_i2c, bus.m_cmd, bus.m_din} !== 12'd0)
      $display("FAIL midreset_master got=%b/%0d/%h exp=0", bus.m_wr_i2c, bus.m_cmd, bus.m_din);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (log_q.size() !== 3)
      $display("FAIL midreset_nostop got=%0d exp=3", log_q.size());
    else n_pass++;
    min_dur = 1;
    max_dur = 4;
    slave_rd = 8'hC3;
    run_req(1'b1, 7'h11, 8'h80, 8'h00);
    model(1'b1, 7'h11, 8'h80, 8'h00, slave_rd);
    n_chk++;
    if (!seq_match() || o_rdata !== 8'hC3)
      $display("FAIL midreset_recover idx=%0d got=%h exp=%h rd=%h", g_idx, g_got, g_exp, o_rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    int rsp1, acc2;
    bit okA, early;
    bit nackA;
    nk_q.delete();
    ack_q.delete();
    log_q.delete();
    slave_rd = 8'h6B;
    @(negedge clk);
    bus.req_rnw = 1'b0;
    bus.req_dev_addr = 7'h2A;
    bus.req_reg_addr = 8'h01;
    bus.req_wdata = 8'hF0;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_rnw = 1'b1;
    bus.req_dev_addr = 7'h3B;
    bus.req_reg_addr = 8'h02;
    bus.req_wdata = 8'h0F;
    rsp1 = -1; acc2 = -1; okA = 0; early = 0; nackA = 1;
    n = 0;
    while (acc2 < 0 && n < 3000) begin
      if (bus.rsp_valid && rsp1 < 0) begin
        rsp1 = cyc;
        nackA = bus.rsp_nack;
        model(1'b0, 7'h2A, 8'h01, 8'hF0, slave_rd);
        okA = seq_match();
        log_q.delete();
      end else if (bus.req_ready) begin
        if (rsp1 < 0) early = 1;
        else acc2 = cyc;
      end
      if (acc2 < 0) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++;
    if (okA !== 1'b1 || nackA !== 1'b0)
      $display("FAIL b2b_first got=%b/%b exp=1/0", okA, nackA);
    else n_pass++;
    n_chk++;
    if (early !== 1'b0 || rsp1 < 0 || acc2 !== rsp1 + 1)
      $display("FAIL b2b_accept got=%0d exp=%0d early=%b", acc2, rsp1 + 1, early);
    else n_pass++;
    n = 0;
    while (!bus.rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    model(1'b1, 7'h3B, 8'h02, 8'h0F, slave_rd);
    n_chk++;
    if (!seq_match())
      $display("FAIL b2b_second_seq idx=%0d got=%h exp=%h", g_idx, g_got, g_exp);
    else n_pass++;
    n_chk++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h6B)
      $display("FAIL b2b_second_rsp got=%b/%h exp=1/6b", bus.rsp_valid, bus.rsp_rdata);
    else n_pass++;
    n_chk++;
    if (viol !== 0)
      $display("FAIL wr_while_busy got=%0d exp=0", viol);
    else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_rnw = 1'b0;
    bus.req_dev_addr = 7'd0;
    bus.req_reg_addr = 8'd0;
    bus.req_wdata = 8'd0;
    test_reset();
    test_write();
    test_read();
    test_nack_abort();
    test_random();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
